core_cycle_controller: RTL and testbench
========================================

Name: core_cycle_controller

Overview:
- Sequences the magnetic-core memory read/regenerate cycle for the 1620 core array.
- Arbitrates the single core array between two requesters: CPU and console (manual entry/display).
- Drives the read/write drive gates, sense strobe and per-bit inhibit lines.
- Returns the sensed digit with an odd-parity check over the 6-bit digit (C,F,8,4,2,1).

Parameters:
- T_READ, 4, read-drive phase length in clocks (min 2).
- T_WRITE, 4, write-drive phase length in clocks (min 1).
- T_REC, 2, recovery phase length in clocks (min 1).
- MEM_DIGITS, 20000, number of addressable digits.
- AW, 15, address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU request; held until cpu_ack.
- cpu_we  in  1  1 = store cpu_wdata, 0 = read/regenerate.
- cpu_addr  in  AW  CPU digit address.
- cpu_wdata  in  6  CPU store data {C,F,8,4,2,1}.
- cpu_ack  out  1  one-clock pulse: CPU cycle complete.
- con_req  in  1  console request; held until con_ack.
- con_we  in  1  console write enable.
- con_addr  in  AW  console address.
- con_wdata  in  6  console store data.
- con_ack  out  1  one-clock pulse: console cycle complete.
- rdata  out  6  digit sensed during the last cycle (old contents).
- rdata_valid  out  1  one-clock pulse, coincident with ack.
- parity_err  out  1  valid with rdata_valid; 1 = sensed digit has an even bit count.
- addr_err  out  1  one-clock pulse, coincident with ack, for an out-of-range address.
- busy  out  1  high in every state except IDLE.
- mar  out  AW  latched core address.
- read_drive  out  1  read current gate.
- write_drive  out  1  write current gate.
- inhibit  out  6  per-bit inhibit; 1 = keep that bit 0.
- sense_strobe  out  1  sense amplifier strobe.
- sense_in  in  6  sense amplifier outputs.

Behaviour:
- Reset (asynchronous, immediate, also mid-cycle):
  - state = IDLE.
  - read_drive, write_drive, sense_strobe, inhibit, busy, both acks, rdata_valid, parity_err, addr_err = 0.
  - mar = 0, rdata = 0.
  - An aborted cycle produces no ack; the requester must re-request.
- States: IDLE -> READ -> WRITE -> RECOVER -> IDLE, plus ERR.
- IDLE:
  - If con_req, grant console; else if cpu_req, grant CPU.
  - On simultaneous requests the console wins.
  - At the grant edge, latch addr, we and wdata of the granted requester; the latched values are held for the whole cycle.
  - Requester inputs are ignored outside IDLE.
  - If addr >= MEM_DIGITS, go to ERR; else go to READ with a phase counter.
- ERR (1 clock):
  - Ack the granted requester; pulse addr_err and rdata_valid.
  - rdata unchanged; no drives asserted.
  - Next state IDLE.
- READ (T_READ clocks):
  - read_drive = 1.
  - sense_strobe = 1 only in the final READ clock.
  - At the edge ending that clock: MBR <= sense_in; parity_err_reg <= ~^sense_in (even count = error).
- WRITE (T_WRITE clocks):
  - write_drive = 1.
  - inhibit = ~latched_wdata if we, else ~MBR (regenerate, written as-is even on a parity error).
  - inhibit is 0 in all other states.
- RECOVER (T_REC clocks):
  - All drives are off.
  - In the final RECOVER clock: granted ack = 1, rdata_valid = 1, rdata = MBR, parity_err = parity_err_reg.
  - Next state is always IDLE. At least one IDLE clock separates cycles.
  - Requesters drop req in the clock after ack.
- Latency: ack is asserted T_READ+T_WRITE+T_REC clocks after the grant edge (10 with defaults).
- mar is valid from the grant edge through RECOVER and holds its value in IDLE.
- Counters are sized to the largest phase parameter. No overlap exists between read_drive and write_drive.

Test Plan:
- Reset, then CPU read of addr 100 with sense_in=6'b000001:
  - read_drive high for clocks 1-4; strobe in clock 4.
  - write_drive clocks 5-8 with inhibit=6'b111110.
  - cpu_ack, rdata=6'b000001, parity_err=0 at clock 10.
- CPU write of 6'b100011 to addr 19999:
  - inhibit=6'b011100 during WRITE.
  - rdata = old sensed digit; cpu_ack at clock 10.
- Read with sense_in=6'b000011:
  - parity_err=1 with rdata_valid.
  - Regenerate inhibit=6'b111100.
- con_req and cpu_req raised in the same clock:
  - console is served first (con_ack).
  - One IDLE clock follows, then the CPU cycle; cpu_ack 11 clocks after con_ack.
- CPU read of addr 20000:
  - ERR state; cpu_ack, addr_err and rdata_valid pulse 1 clock after the grant.
  - No read_drive or write_drive.
- rst_n low during WRITE clock 2:
  - write_drive and inhibit drop immediately; no ack.
  - After release, a new request completes normally.

Source files
------------

// File: rtl/core_cycle_controller.sv
// core_cycle_controller
//
// Sequences the destructive-read / regenerate cycle of the 1620 magnetic-core
// digit array and arbitrates the array between the CPU and the console.
//
// A cycle runs IDLE -> READ -> WRITE -> RECOVER -> IDLE. An out-of-range
// address takes IDLE -> ERR -> IDLE instead, and no drive current is applied.
// During READ the selected digit is driven to zero and the sense amplifiers
// report the old contents. During WRITE all six planes are driven towards 1,
// and the inhibit line of every bit that must stay 0 is asserted.
//
// Handshake: a requester raises req (with we/addr/wdata) and holds it until it
// sees its one-clock ack. It drops req in the clock after ack. Requests are
// only sampled in IDLE, and the console wins a tie. The granted requester's
// addr/we/wdata are latched at the grant edge and used for the whole cycle.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata       CPU request channel
//   cpu_ack                     CPU cycle complete (one clock)
//   con_req/we/addr/wdata       console request channel
//   con_ack                     console cycle complete (one clock)
//   rdata, rdata_valid          old digit contents, valid with ack
//   parity_err                  sensed digit has an even bit count (with rdata_valid)
//   addr_err                    address >= MEM_DIGITS (with ack)
//   busy                        any state other than IDLE
//   mar                         latched core address
//   read_drive, write_drive     drive current gates
//   inhibit                     per-bit inhibit, 1 = keep that bit 0
//   sense_strobe, sense_in      sense amplifier strobe and outputs
//   state_dbg                   current FSM state encoding
module core_cycle_controller #(
  parameter int T_READ     = 4,
  parameter int T_WRITE    = 4,
  parameter int T_REC      = 2,
  parameter int MEM_DIGITS = 20000,
  parameter int AW         = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [5:0]    cpu_wdata,
  output logic          cpu_ack,
  input  logic          con_req,
  input  logic          con_we,
  input  logic [AW-1:0] con_addr,
  input  logic [5:0]    con_wdata,
  output logic          con_ack,
  output logic [5:0]    rdata,
  output logic          rdata_valid,
  output logic          parity_err,
  output logic          addr_err,
  output logic          busy,
  output logic [AW-1:0] mar,
  output logic          read_drive,
  output logic          write_drive,
  output logic [5:0]    inhibit,
  output logic          sense_strobe,
  input  logic [5:0]    sense_in,
  output logic [2:0]    state_dbg
);

  // Phase counter is sized for the longest phase.
  localparam int T_MAX_RW = (T_READ > T_WRITE) ? T_READ : T_WRITE;
  localparam int T_MAX    = (T_MAX_RW > T_REC) ? T_MAX_RW : T_REC;
  localparam int CW       = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_WRITE   = 3'd2,
    S_RECOVER = 3'd3,
    S_ERR     = 3'd4
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic          phase_last;

  // Cycle context latched at the grant edge.
  logic          grant_con;
  logic          lat_we;
  logic [5:0]    lat_wdata;

  // Memory buffer register: digit sensed in the final READ clock.
  logic [5:0]    mbr;
  logic          par_q;
  // Digit returned by the most recent completed cycle.
  logic [5:0]    rdata_q;

  // Arbitration: console has priority over CPU.
  logic          any_req;
  logic          sel_con;
  logic [AW-1:0] sel_addr;
  logic          sel_we;
  logic [5:0]    sel_wdata;
  logic          sel_out_of_range;

  logic          cycle_done;
  logic          err_done;

  assign any_req   = con_req | cpu_req;
  assign sel_con   = con_req;
  assign sel_addr  = sel_con ? con_addr  : cpu_addr;
  assign sel_we    = sel_con ? con_we    : cpu_we;
  assign sel_wdata = sel_con ? con_wdata : cpu_wdata;

  // Widen to 32 bits so the compare works for any AW.
  assign sel_out_of_range = ({{(32-AW){1'b0}}, sel_addr} >= 32'(MEM_DIGITS));

  // True in the final clock of the current timed phase.
  always_comb begin
    phase_last = 1'b0;
    case (state)
      S_READ:    phase_last = (cnt == CW'(T_READ  - 1));
      S_WRITE:   phase_last = (cnt == CW'(T_WRITE - 1));
      S_RECOVER: phase_last = (cnt == CW'(T_REC   - 1));
      default:   phase_last = 1'b0;
    endcase
  end

  // State register and phase counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      // Restart the counter on every state change so each phase starts at 0.
      if (state_next != state) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          state_next = sel_out_of_range ? S_ERR : S_READ;
        end
      end
      S_READ: begin
        if (phase_last) state_next = S_WRITE;
      end
      S_WRITE: begin
        if (phase_last) state_next = S_RECOVER;
      end
      S_RECOVER: begin
        if (phase_last) state_next = S_IDLE;
      end
      S_ERR: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath registers: grant context, MBR and returned digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_con <= 1'b0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      mar       <= '0;
      mbr       <= '0;
      par_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (state == S_IDLE && any_req) begin
        grant_con <= sel_con;
        lat_we    <= sel_we;
        lat_wdata <= sel_wdata;
        mar       <= sel_addr;
      end
      if (state == S_READ && phase_last) begin
        mbr   <= sense_in;
        // Odd parity over C,F,8,4,2,1: an even bit count is an error.
        par_q <= ~^sense_in;
      end
      if (cycle_done) begin
        rdata_q <= mbr;
      end
    end
  end

  assign cycle_done = (state == S_RECOVER) && phase_last;
  assign err_done   = (state == S_ERR);

  // Output logic, decoded from the registered state and counter.
  always_comb begin
    read_drive   = 1'b0;
    write_drive  = 1'b0;
    sense_strobe = 1'b0;
    inhibit      = '0;
    cpu_ack      = 1'b0;
    con_ack      = 1'b0;
    rdata_valid  = 1'b0;
    parity_err   = 1'b0;
    addr_err     = 1'b0;
    rdata        = rdata_q;
    busy         = (state != S_IDLE);
    case (state)
      S_READ: begin
        read_drive   = 1'b1;
        sense_strobe = phase_last;
      end
      S_WRITE: begin
        write_drive = 1'b1;
        // A store writes the new digit; a read regenerates the sensed digit
        // exactly as read, even when its parity is bad.
        inhibit = lat_we ? ~lat_wdata : ~mbr;
      end
      S_RECOVER: begin
        if (phase_last) begin
          cpu_ack     = ~grant_con;
          con_ack     = grant_con;
          rdata_valid = 1'b1;
          rdata       = mbr;
          parity_err  = par_q;
        end
      end
      S_ERR: begin
        cpu_ack     = ~grant_con;
        con_ack     = grant_con;
        rdata_valid = 1'b1;
        addr_err    = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_core_cycle_controller.sv
// Testbench for core_cycle_controller.
module tb_core_cycle_controller;

  localparam int AW = 15;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [5:0]    cpu_wdata = '0;
  logic          cpu_ack;
  logic          con_req = 1'b0;
  logic          con_we = 1'b0;
  logic [AW-1:0] con_addr = '0;
  logic [5:0]    con_wdata = '0;
  logic          con_ack;
  logic [5:0]    rdata;
  logic          rdata_valid;
  logic          parity_err;
  logic          addr_err;
  logic          busy;
  logic [AW-1:0] mar;
  logic          read_drive;
  logic          write_drive;
  logic [5:0]    inhibit;
  logic          sense_strobe;
  logic [5:0]    sense_in = '0;
  logic [2:0]    state_dbg;

  core_cycle_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_ack      (cpu_ack),
    .con_req      (con_req),
    .con_we       (con_we),
    .con_addr     (con_addr),
    .con_wdata    (con_wdata),
    .con_ack      (con_ack),
    .rdata        (rdata),
    .rdata_valid  (rdata_valid),
    .parity_err   (parity_err),
    .addr_err     (addr_err),
    .busy         (busy),
    .mar          (mar),
    .read_drive   (read_drive),
    .write_drive  (write_drive),
    .inhibit      (inhibit),
    .sense_strobe (sense_strobe),
    .sense_in     (sense_in),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard ----------------
  // Result word: {cpu_ack, con_ack, rdata_valid, addr_err, parity_err, rdata}
  logic [10:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  logic [5:0] last_rdata = '0;

  // Per-clock trace of one cycle, clock 1 = first clock after the grant edge.
  logic       tr_rd   [1:40];
  logic       tr_wd   [1:40];
  logic       tr_st   [1:40];
  logic       tr_busy [1:40];
  logic [5:0] tr_inh  [1:40];

  function automatic logic [10:0] mk_res(input logic c_ack, input logic k_ack,
                                         input logic aerr, input logic [5:0] d,
                                         input logic perr);
    return {c_ack, k_ack, 1'b1, aerr, perr, d};
  endfunction

  function automatic logic [10:0] obs_res();
    return {cpu_ack, con_ack, rdata_valid, addr_err, parity_err, rdata};
  endfunction

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge with the DUT idle. Raises one request,
  // traces every clock until the ack (bounded) and drops req the clock after.
  task automatic drive_cycle(input bit is_con, input bit we,
                             input logic [AW-1:0] addr, input logic [5:0] wdata,
                             input logic [5:0] sense,
                             output int ack_k, output logic [10:0] got);
    sense_in = sense;
    if (is_con) begin
      con_req = 1'b1; con_we = we; con_addr = addr; con_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    ack_k = 0;
    got   = '0;
    @(posedge clk);  // grant edge
    for (int k = 1; k <= 40; k++) begin
      #1;
      tr_rd[k]   = read_drive;
      tr_wd[k]   = write_drive;
      tr_st[k]   = sense_strobe;
      tr_busy[k] = busy;
      tr_inh[k]  = inhibit;
      if (cpu_ack || con_ack) begin
        ack_k = k;
        got   = obs_res();
        break;
      end
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    con_req = 1'b0;
  endtask

  // Pops the expected result and compares it with the observed one.
  task automatic score(input string name, input int ack_k, input logic [10:0] got);
    logic [10:0] exp;
    n_cmp++;
    if (ack_k == 0) begin
      n_fail++;
      $display("FAIL %s: no ack within 40 clocks", name);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected ack, got %b", name, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s result: got %b expected %b", name, got, exp);
      end else begin
        last_rdata = exp[5:0];
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    n_cmp++;
    if ({busy, read_drive, write_drive, sense_strobe, inhibit, cpu_ack, con_ack,
         rdata_valid, parity_err, addr_err} !== 15'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0", {busy, read_drive, write_drive,
               sense_strobe, inhibit, cpu_ack, con_ack, rdata_valid, parity_err, addr_err});
    end
    n_cmp++;
    if (mar !== '0 || rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: mar=%0d rdata=%b expected 0/0", mar, rdata);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Checks drive timing of one normal cycle against the phase plan.
  task automatic check_trace(input string name, input int ack_k, input logic [5:0] exp_inh);
    n_cmp++;
    if (ack_k != 10) begin
      n_fail++;
      $display("FAIL %s latency: ack at clock %0d expected 10", name, ack_k);
    end
    for (int k = 1; k <= 10 && k <= ack_k; k++) begin
      logic e_rd, e_wd, e_st;
      logic [5:0] e_inh;
      e_rd  = (k >= 1 && k <= 4);
      e_st  = (k == 4);
      e_wd  = (k >= 5 && k <= 8);
      e_inh = e_wd ? exp_inh : 6'b0;
      n_cmp++;
      if ({tr_rd[k], tr_st[k], tr_wd[k], tr_inh[k], tr_busy[k]} !== {e_rd, e_st, e_wd, e_inh, 1'b1}) begin
        n_fail++;
        $display("FAIL %s clk%0d: rd/st/wd/inh/busy got %b%b%b %b %b expected %b%b%b %b 1",
                 name, k, tr_rd[k], tr_st[k], tr_wd[k], tr_inh[k], tr_busy[k],
                 e_rd, e_st, e_wd, e_inh);
      end
    end
  endtask

  task automatic test_cpu_read();
    int ack_k; logic [10:0] got;
    logic [5:0] s = 6'b000001;
    exp_q.push_back(mk_res(1'b1, 1'b0, 1'b0, s, ~^s));
    drive_cycle(1'b0, 1'b0, 15'd100, 6'd0, s, ack_k, got);
    check_trace("cpu_read", ack_k, ~s);
    score("cpu_read", ack_k, got);
    n_cmp++;
    if (mar !== 15'd100) begin
      n_fail++;
      $display("FAIL cpu_read mar: got %0d expected 100", mar);
    end
  endtask

  task automatic test_cpu_write();
    int ack_k; logic [10:0] got;
    logic [5:0] s = 6'b000111;
    logic [5:0] w = 6'b100011;
    exp_q.push_back(mk_res(1'b1, 1'b0, 1'b0, s, ~^s));
    drive_cycle(1'b0, 1'b1, 15'd19999, w, s, ack_k, got);
    check_trace("cpu_write", ack_k, 6'b011100);
    score("cpu_write", ack_k, got);
  endtask

  task automatic test_parity();
    int ack_k; logic [10:0] got;
    logic [5:0] s = 6'b000011;
    exp_q.push_back(mk_res(1'b1, 1'b0, 1'b0, s, 1'b1));
    drive_cycle(1'b0, 1'b0, 15'd5, 6'd0, s, ack_k, got);
    check_trace("parity", ack_k, 6'b111100);
    score("parity", ack_k, got);
  endtask

  task automatic test_random_reads();
    int ack_k; logic [10:0] got;
    logic [5:0] s;
    logic [AW-1:0] a;
    for (int i = 0; i < 3; i++) begin
      s = 6'($urandom_range(0, 63));
      a = 15'($urandom_range(0, 19999));
      exp_q.push_back(mk_res(1'b0, 1'b1, 1'b0, s, ~^s));
      drive_cycle(1'b1, 1'b0, a, 6'd0, s, ack_k, got);
      check_trace("con_rand", ack_k, ~s);
      score("con_rand", ack_k, got);
    end
  endtask

  // Console and CPU request in the same clock.
  task automatic test_back_to_back();
    int con_k = 0, cpu_k = 0;
    bit drop_con = 0, drop_cpu = 0;
    logic [5:0] s = 6'b010101;
    sense_in = s;
    exp_q.push_back(mk_res(1'b0, 1'b1, 1'b0, s, ~^s));
    exp_q.push_back(mk_res(1'b1, 1'b0, 1'b0, s, ~^s));
    con_req = 1'b1; con_we = 1'b0; con_addr = 15'd7;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd8;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      #1;
      if (drop_con) begin con_req = 1'b0; drop_con = 0; end
      if (drop_cpu) begin cpu_req = 1'b0; drop_cpu = 0; end
      if (con_k != 0 && k == con_k + 1) begin
        n_cmp++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b idle_gap: busy got %b expected 0", busy);
        end
      end
      if (con_ack) begin
        con_k = k; drop_con = 1;
        score("b2b_con", k, obs_res());
        n_cmp++;
        if (cpu_k != 0) begin
          n_fail++;
          $display("FAIL b2b order: cpu_ack at %0d before con_ack at %0d", cpu_k, k);
        end
      end
      if (cpu_ack) begin
        cpu_k = k; drop_cpu = 1;
        score("b2b_cpu", k, obs_res());
        break;
      end
      @(posedge clk);
    end
    n_cmp++;
    if (con_k != 10 || cpu_k - con_k != 11) begin
      n_fail++;
      $display("FAIL b2b timing: con_ack %0d cpu_ack %0d expected 10 and 21", con_k, cpu_k);
    end
    @(posedge clk); #1;
    con_req = 1'b0; cpu_req = 1'b0;
  endtask

  task automatic test_addr_err();
    int ack_k; logic [10:0] got;
    exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b1, 1'b0, last_rdata});
    drive_cycle(1'b0, 1'b0, 15'd20000, 6'd0, 6'b111111, ack_k, got);
    n_cmp++;
    if (ack_k != 1) begin
      n_fail++;
      $display("FAIL addr_err latency: ack at clock %0d expected 1", ack_k);
    end
    n_cmp++;
    if (ack_k >= 1 && (tr_rd[1] !== 1'b0 || tr_wd[1] !== 1'b0)) begin
      n_fail++;
      $display("FAIL addr_err drives: rd %b wd %b expected 0 0", tr_rd[1], tr_wd[1]);
    end
    score("addr_err", ack_k, got);
  endtask

  // Reset asserted in the second WRITE clock aborts the cycle silently.
  task automatic test_reset_mid_write();
    int ack_k; logic [10:0] got;
    int acks = 0;
    logic [5:0] s = 6'b110100;
    sense_in = s;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd42;
    @(posedge clk);
    for (int k = 1; k < 6; k++) @(posedge clk);
    #1;
    n_cmp++;
    if (write_drive !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset pre: write_drive got %b expected 1", write_drive);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({write_drive, inhibit, busy, read_drive} !== 9'b0 || mar !== '0 || rdata !== '0) begin
      n_fail++;
      $display("FAIL mid_reset drop: wd %b inh %b busy %b mar %0d rdata %b expected all 0",
               write_drive, inhibit, busy, mar, rdata);
    end
    cpu_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (k == 2) begin
        #2 rst_n = 1'b1;
      end
      if (cpu_ack || con_ack) acks++;
    end
    n_cmp++;
    if (acks != 0) begin
      n_fail++;
      $display("FAIL mid_reset ack: got %0d acks expected 0", acks);
    end
    @(posedge clk); #1;
    exp_q.push_back(mk_res(1'b1, 1'b0, 1'b0, s, ~^s));
    drive_cycle(1'b0, 1'b0, 15'd42, 6'd0, s, ack_k, got);
    check_trace("post_reset", ack_k, ~s);
    score("post_reset", ack_k, got);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_parity();
    test_random_reads();
    test_back_to_back();
    test_addr_err();
    test_reset_mid_write();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d expected results never produced, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
